// File: rtl/decoder_if.sv
// rtl/decoder_if.sv - decoder bus interface; DECODER_STICKY_ERROR_EN adds the sticky-error signals
interface decoder_if #(
    parameter int NUM_OUTPUT = 5
);
    localparam int AW = $clog2(NUM_OUTPUT);

    logic                  in_enable;
    logic [AW-1:0]         in_address;
    logic [NUM_OUTPUT-1:0] out_select;
    logic                  out_error;
`ifdef DECODER_STICKY_ERROR_EN
    logic                  in_err_clear;
    logic                  out_err_sticky;

    modport master (
        output in_enable, in_address, in_err_clear,
        input  out_select, out_error, out_err_sticky
    );

    modport slave (
        input  in_enable, in_address, in_err_clear,
        output out_select, out_error, out_err_sticky
    );
`else
    modport master (
        output in_enable, in_address,
        input  out_select, out_error
    );

    modport slave (
        input  in_enable, in_address,
        output out_select, out_error
    );
`endif
endinterface

// File: rtl/decoder.sv
// rtl/decoder.sv - registered binary-to-one-hot decoder with out-of-range flag; DECODER_STICKY_ERROR_EN adds a sticky error bit
module decoder #(
    parameter int NUM_OUTPUT = 5
) (
    input  logic      in_clk,
    input  logic      in_rst,
    decoder_if.slave  bus
);
    localparam int AW = $clog2(NUM_OUTPUT);

    generate
        if (NUM_OUTPUT < 2) begin : g_bad_param
            $error("decoder: NUM_OUTPUT must be 2 or more");
        end
    endgenerate

    logic                  in_range;
    logic [NUM_OUTPUT-1:0] select_next;
    logic                  error_next;
    logic [NUM_OUTPUT-1:0] select_q;
    logic                  error_q;

    // With a power-of-two output count every address maps to an output,
    // so the range compare is dropped rather than left as a constant test.
    generate
        if ((1 << AW) == NUM_OUTPUT) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_npow2
            assign in_range = {1'b0, bus.in_address} < (AW + 1)'(NUM_OUTPUT);
        end
    endgenerate

    // Next-cycle select and error values from the sampled enable/address
    always_comb begin
        select_next = '0;
        error_next  = 1'b0;
        if (bus.in_enable) begin
            if (in_range) begin
                select_next = {{(NUM_OUTPUT - 1){1'b0}}, 1'b1} << bus.in_address;
            end else begin
                error_next = 1'b1;
            end
        end
    end

    // Output registers; reset clears them without waiting for a clock edge
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            select_q <= '0;
            error_q  <= 1'b0;
        end else begin
            select_q <= select_next;
            error_q  <= error_next;
        end
    end

    assign bus.out_select = select_q;
    assign bus.out_error  = error_q;

`ifdef DECODER_STICKY_ERROR_EN
    logic sticky_q;

    // Sticky error: a new error on the same edge as a clear takes priority
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            sticky_q <= 1'b0;
        end else if (error_next) begin
            sticky_q <= 1'b1;
        end else if (bus.in_err_clear) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.out_err_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - randomized self-checking bench for decoder; honours DECODER_STICKY_ERROR_EN
module tb_decoder;
    localparam int N  = 5;
    localparam int AW = $clog2(N);

    logic in_clk = 1'b0;
    logic in_rst = 1'b1;

    decoder_if #(.NUM_OUTPUT(N)) bus ();

    decoder #(.NUM_OUTPUT(N)) dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus)
    );

    always #5 in_clk = ~in_clk;

    int   tests = 0;
    int   fails = 0;
    logic sticky_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_select(input logic en, input int addr);
        if (en && addr < N) return 1 << addr;
        return 0;
    endfunction

    function automatic int exp_error(input logic en, input int addr);
        return (en && addr >= N) ? 1 : 0;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".sel"}, 32'(bus.out_select), 0);
        check({tag, ".err"}, 32'(bus.out_error), 0);
`ifdef DECODER_STICKY_ERROR_EN
        check({tag, ".sticky"}, 32'(bus.out_err_sticky), 0);
`endif
    endtask

    task automatic check_outputs(input string tag, input logic en, input int addr);
        check({tag, ".sel"}, 32'(bus.out_select), exp_select(en, addr));
        check({tag, ".err"}, 32'(bus.out_error), exp_error(en, addr));
        check({tag, ".onehot"}, 32'($countones(bus.out_select) <= 1), 1);
        check({tag, ".exclusive"}, 32'((bus.out_select != '0) && bus.out_error), 0);
`ifdef DECODER_STICKY_ERROR_EN
        check({tag, ".sticky"}, 32'(bus.out_err_sticky), 32'(sticky_m));
`endif
    endtask

    // Drive one cycle of inputs just after an edge, then check after the next edge.
    task automatic step(input string tag, input logic en, input int addr, input logic clr);
        bus.in_enable  = en;
        bus.in_address = AW'(addr);
`ifdef DECODER_STICKY_ERROR_EN
        bus.in_err_clear = clr;
`endif
        @(posedge in_clk);
        #1;
        if (exp_error(en, addr) != 0) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
        check_outputs(tag, en, addr);
    endtask

    // Decode a cycle, pulse reset between edges, then confirm decode resumes.
    task automatic mid_reset(input logic en, input int addr);
        step("pre_rst", en, addr, 1'b0);
        #2 in_rst = 1'b1;
        #1;
        sticky_m = 1'b0;
        check_zero("async_rst");
        #2 in_rst = 1'b0;
        #1;
        check_zero("rst_hold");
        @(posedge in_clk);
        #1;
        if (exp_error(en, addr) != 0) sticky_m = 1'b1;
        check_outputs("post_rst", en, addr);
    endtask

    initial begin
        bus.in_enable  = 1'b0;
        bus.in_address = '0;
`ifdef DECODER_STICKY_ERROR_EN
        bus.in_err_clear = 1'b0;
`endif
        #2;
        check_zero("reset");
        #1 in_rst = 1'b0;
        #1;
        check_zero("reset_release");
        @(posedge in_clk);
        #1;
        check_zero("first_edge_idle");

        for (int a = 0; a < N; a++) step("sweep", 1'b1, a, 1'b0);
        for (int a = N; a < (1 << AW); a++) step("oor", 1'b1, a, 1'b0);
        step("after_oor", 1'b1, 2, 1'b0);

        step("gate_a3", 1'b0, 3, 1'b0);
        step("gate_a6", 1'b0, 6, 1'b0);
        step("gate_on", 1'b1, 3, 1'b0);

        mid_reset(1'b1, 1);
        mid_reset(1'b1, 4);

`ifdef DECODER_STICKY_ERROR_EN
        step("sticky_set", 1'b1, 7, 1'b0);
        step("sticky_hold", 1'b1, 1, 1'b0);
        step("sticky_clear", 1'b1, 1, 1'b1);
        step("sticky_set_wins", 1'b1, 6, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic en;
            int   addr;
            logic clr;
            en   = ($urandom_range(0, 3) != 0);
            addr = $urandom_range(0, (1 << AW) - 1);
            clr  = ($urandom_range(0, 3) == 0);
            if (i % 37 == 36) mid_reset(en, addr);
            else step("rand", en, addr, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decoder.md
Name: decoder

Overview:
Registered binary-to-one-hot address decoder with out-of-range detection.
- Converts an address of width $clog2(NUM_OUTPUT) into a one-hot select vector of NUM_OUTPUT bits.
- Flags addresses that have no corresponding output (address >= NUM_OUTPUT); these occur when NUM_OUTPUT is not a power of two.
- Sits in front of peripheral/bank select logic. Outputs are registered, giving one cycle of latency.

Parameters:
NUM_OUTPUT, 5, number of select outputs. Legal range is 2 or more; NUM_OUTPUT < 2 is a compile-time error.
AW, $clog2(NUM_OUTPUT) (localparam, not overridable), address width. For NUM_OUTPUT=5, AW=3.

Ports:
in_clk  input  1  clock; all state changes on the rising edge.
in_rst  input  1  asynchronous, active-high reset.
in_enable  input  1  decode enable; sampled on in_clk.
in_address  input  AW  binary address to decode.
out_select  output  NUM_OUTPUT  registered one-hot select vector.
out_error  output  1  registered out-of-range flag.

Behaviour:
- Reset: in_rst=1 forces out_select=0 and out_error=0 immediately, with no wait for a clock edge. Outputs hold these values while reset is asserted. The first update happens on the first rising in_clk edge after in_rst deasserts.
- Latency: exactly 1 cycle. Outputs after rising edge N reflect in_enable/in_address sampled at edge N.
- in_enable=1, in_address < NUM_OUTPUT:
  - out_select[in_address]=1, all other bits 0.
  - out_error=0.
- in_enable=1, in_address >= NUM_OUTPUT (e.g. 5, 6, 7 when NUM_OUTPUT=5):
  - out_select=0 (no bit set).
  - out_error=1.
- in_enable=0: out_select=0 and out_error=0, regardless of address.
- Invariant: at most one bit of out_select is set at any time. out_select != 0 and out_error=1 never occur together.
- Power-of-two NUM_OUTPUT (e.g. 4, 8): out_error is constant 0. No out-of-range address exists; the tool may optimise the flag away.
- X/Z on in_address while enabled: no requirement beyond simulation propagation. Verification does not drive X while enabled.
- Address changes on consecutive cycles: each cycle is decoded independently. There is no hold or hysteresis.
- Reset asserted mid-stream: outputs clear asynchronously. Any pending decode is discarded.
- Purely synchronous datapath apart from the reset. No combinational path from inputs to outputs.

Optional Feature:
Macro DECODER_STICKY_ERROR_EN.
- Defined:
  - Adds input in_err_clear (1 bit) and output out_err_sticky (1 bit).
  - out_err_sticky is set on any cycle in which out_error is registered as 1. It stays 1 until in_err_clear=1 is sampled on a rising edge, or until reset.
  - Clear and a new error on the same edge: the set wins (out_err_sticky=1).
  - Reset value is 0.
- Not defined: neither port exists. Behaviour is otherwise identical.

Test Plan:
- Reset: in_rst=1 with no clock edge -> out_select=5'b00000, out_error=0 immediately. Release reset -> outputs unchanged until the first edge.
- Sweep with NUM_OUTPUT=5, in_enable=1, address 0..4 -> one cycle later out_select=00001, 00010, 00100, 01000, 10000, with out_error=0 each time.
- Out-of-range with in_enable=1: address 5, 6, 7 -> out_select=00000, out_error=1 one cycle later. Then address 2 -> 00100, out_error=0.
- Enable gating: address=3, in_enable=0 -> out_select=00000, out_error=0. Address=6, in_enable=0 -> out_error=0. Raise enable with address=3 -> 01000 next cycle.
- Async reset mid-stream: during the sweep, assert in_rst between clock edges -> outputs go to 0 before the next edge. Deassert -> decode resumes on the following edge.
- With DECODER_STICKY_ERROR_EN defined: address 7 -> out_err_sticky=1. Address 1 -> out_err_sticky stays 1. in_err_clear=1 -> 0 next cycle. Clear together with address 6 on the same edge -> out_err_sticky=1.
